// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding and byte-lane merge.
package ram_arb_pkg;

  typedef enum logic {
    S_ACCEPT = 1'b0,
    S_MERGE  = 1'b1
  } arb_state_e;

  // Widest word the merge helper handles; callers cast to and from their own width.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(MAX_BE_WIDTH); b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side request/response bus of the RAM arbiter, packed per requester.
interface ram_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            i_req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata;
  logic [NUM_REQ*BE_WIDTH-1:0]   i_req_be;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0]         o_rsp_data;

  // Requesters drive requests and sink responses.
  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
    input  o_req_ready, o_rsp_valid, o_rsp_data
  );

  // The arbiter consumes requests and produces grants and responses.
  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
    output o_req_ready, o_rsp_valid, o_rsp_data
  );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = (IDX_W+1)'(i_ptr) + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = IDX_W'(sum);
      if (!found && i_valid[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one read-first single-port RAM between NUM_REQ requesters.
// Define RAM_ARB_RMW_EN to add byte-enable writes via a read-modify-write merge cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  ram_arbiter_if.slave             bus,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]    o_ram_data,
  output logic                     o_ram_we,
  input  logic [DATA_WIDTH-1:0]    i_ram_data
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      nxt_ptr;
  logic                  accept_en;
  logic [NUM_REQ-1:0]    arb_valid;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  hs;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  full_we;
  logic                  rsp_pend;
  logic [IDX_W-1:0]      rsp_id;

`ifdef RAM_ARB_RMW_EN
  arb_state_e            state;
  logic                  partial;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;
  logic [IDX_W-1:0]      lat_id;
  logic [DATA_WIDTH-1:0] old_word;
  logic                  rsp_old;
  logic [DATA_WIDTH-1:0] merged;

  assign accept_en = !i_rst && (state == S_ACCEPT);
  assign partial   = sel_we && (sel_be != '0) && (sel_be != '1);
  // An all-zero byte enable degenerates to a read; only all-ones writes go straight to RAM.
  assign full_we   = sel_we && (sel_be == '1);
  assign merged    = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(i_ram_data),
                                            MAX_DATA_WIDTH'(lat_wdata),
                                            MAX_BE_WIDTH'(lat_be)));
`else
  logic unused_be;

  assign accept_en = !i_rst;
  assign full_we   = sel_we;
  assign unused_be = ^sel_be;
`endif

  assign arb_valid = bus.i_req_valid & {NUM_REQ{accept_en}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_valid     (arb_valid),
    .i_ptr       (ptr),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  assign bus.o_req_ready = grant;
  assign hs              = |grant;
  assign nxt_ptr         = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // One-hot mux of the granted requester's payload.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant[k]) begin
        sel_we    = bus.i_req_we[k];
        sel_addr  = bus.i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_be    = bus.i_req_be[k*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  // RAM port: merge write-back, else the granted access, else idle.
  always_comb begin
    o_ram_addr = '0;
    o_ram_data = '0;
    o_ram_we   = 1'b0;
`ifdef RAM_ARB_RMW_EN
    if (!i_rst && (state == S_MERGE)) begin
      o_ram_addr = lat_addr;
      o_ram_data = merged;
      o_ram_we   = 1'b1;
    end else if (hs) begin
      o_ram_addr = sel_addr;
      o_ram_data = sel_wdata;
      o_ram_we   = full_we;
    end
`else
    if (hs) begin
      o_ram_addr = sel_addr;
      o_ram_data = sel_wdata;
      o_ram_we   = full_we;
    end
`endif
  end

  // Response decode from the tag registers.
  always_comb begin
    bus.o_rsp_valid = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      bus.o_rsp_valid[k] = rsp_pend && (rsp_id == IDX_W'(k));
    end
  end

`ifdef RAM_ARB_RMW_EN
  assign bus.o_rsp_data = rsp_old ? old_word : i_ram_data;
`else
  assign bus.o_rsp_data = i_ram_data;
`endif

  // Pointer, FSM, merge latches and response tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr      <= '0;
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
`ifdef RAM_ARB_RMW_EN
      state     <= S_ACCEPT;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_id    <= '0;
      old_word  <= '0;
      rsp_old   <= 1'b0;
`endif
    end else begin
      rsp_pend <= 1'b0;
`ifdef RAM_ARB_RMW_EN
      rsp_old  <= 1'b0;
      case (state)
        S_ACCEPT: begin
          if (hs) begin
            ptr <= nxt_ptr;
            if (partial) begin
              state     <= S_MERGE;
              lat_addr  <= sel_addr;
              lat_wdata <= sel_wdata;
              lat_be    <= sel_be;
              lat_id    <= grant_idx;
            end else begin
              rsp_pend <= 1'b1;
              rsp_id   <= grant_idx;
            end
          end
        end
        S_MERGE: begin
          old_word <= i_ram_data;
          rsp_old  <= 1'b1;
          rsp_pend <= 1'b1;
          rsp_id   <= lat_id;
          state    <= S_ACCEPT;
        end
        default: state <= S_ACCEPT;
      endcase
`else
      if (hs) begin
        ptr      <= nxt_ptr;
        rsp_pend <= 1'b1;
        rsp_id   <= grant_idx;
      end
`endif
    end
  end

endmodule
